uart_iobridge: RTL
==================

UART_IOBRIDGE -- requirements
Module: uart_iobridge

Interface
REQ-001 Parameter BAUD_DIV, default 54: clk cycles per 16x oversample tick (100 MHz / (115200*16)); legal range 2..65535.
REQ-002 clk  in  1  master clock; all logic on posedge.
REQ-003 reset  in  1  master reset; one clock, reset synchronous and active-high.
REQ-004 rxd  in  1  UART serial input from the host; idle high; asynchronous to clk.
REQ-005 txd  out  1  UART serial output to the host; idle high.
REQ-006 rxbyte  out  8  received byte, driven to the I/O port block's datain bus.
REQ-007 load  out  1  one-cycle strobe: rxbyte valid.
REQ-008 txbyte  in  8  byte from the I/O port block's dataout bus.
REQ-009 enout  in  1  I/O port block asserts when txbyte is valid; held high until ready falls.
REQ-010 ready  out  1  bridge can accept a txbyte.
REQ-011 frame_err  out  1  one-cycle strobe: received character rejected.

Function
REQ-012 The block SHALL pass rxd through a 2-flop synchronizer before any use; this adds 2 cycles to RX latency.
REQ-013 Baud generator SHALL emit a 1-cycle tick every BAUD_DIV clk cycles, free-running from reset release.
REQ-014 RX FSM states SHALL be R_IDLE, R_START, R_DATA, R_PAR (only with the macro), R_STOP.
REQ-015 R_IDLE->R_START on a synchronized high-to-low rxd edge; R_START counts 8 ticks; rxd high at count 8 -> R_IDLE (false start, no strobe), else -> R_DATA.
REQ-016 R_DATA SHALL sample 8 bits LSB-first, one every 16 ticks at mid-bit.
REQ-017 R_STOP samples at mid-bit; rxd=1 -> load=1 and rxbyte updated in the next cycle; rxd=0 -> frame_err=1 in the next cycle, load stays 0 and rxbyte holds its old value; either way -> R_IDLE immediately, so a start bit that follows directly is caught.
REQ-018 rxbyte SHALL hold its value between strobes; load and frame_err are never high together.
REQ-019 TX FSM states SHALL be T_IDLE, T_START, T_DATA, T_PAR (only with the macro), T_STOP, T_WAIT; each bit lasts 16 ticks.
REQ-020 In T_IDLE ready=1; enout=1 in T_IDLE -> latch txbyte, ready=0 next cycle, -> T_START.
REQ-021 T_START drives txd=0; T_DATA drives the 8 bits LSB-first; T_STOP drives txd=1.
REQ-022 After T_STOP -> T_WAIT; T_WAIT waits for enout=0, then -> T_IDLE (ready=1 next cycle); a byte is never latched twice.
REQ-023 enout arriving while ready=0 SHALL be ignored until T_IDLE.
REQ-024 RX and TX SHALL operate fully independently; simultaneous activity has no interaction.

Reset
REQ-025 While reset is high: txd=1, ready=0, load=0, frame_err=0, rxbyte=0, both FSMs idle, baud counter=0, synchronizer flops=1.
REQ-026 Reset mid-character SHALL abort it: no strobe is issued, and txd returns to 1 in the next cycle.
REQ-027 ready=1 SHALL appear in the first cycle after reset falls.

Configuration
REQ-028 Macro UART_PARITY_EN: when defined, an even-parity bit SHALL follow the data bits on RX and TX (11-bit frame).
REQ-029 With UART_PARITY_EN defined, an RX parity mismatch SHALL give frame_err instead of load.
REQ-030 Without UART_PARITY_EN, the frame SHALL be 10 bits (8N1), with no parity states or logic.

Structure
REQ-031 Package uart_iobridge_pkg SHALL hold the RX/TX state encodings, OVERSAMPLE=16 and MIDBIT=8.
REQ-032 Sub-module uart_baudgen (tick generator, parameter BAUD_DIV) SHALL be instantiated once and shared by RX and TX.

Verification (BAUD_DIV=4 for all scenarios)
REQ-033 Drive 0xA5 8N1 on rxd -> exactly one load pulse with rxbyte=0xA5, 2+16*9.5*4 +/-4 clk after the start edge.
REQ-034 Host sequence 0x20, 0x12, 0x34, 0x56, 0x78 (write to port 0) -> five load pulses in order; frame_err never high.
REQ-035 Send txbyte=0x3C with enout held high for 3 cycles then low -> ready falls; txd shows 0,0,0,1,1,1,1,0,0,1 at 64 clk/bit; ready=1 after the stop bit.
REQ-036 Stop bit forced to 0 on 0x55 -> frame_err pulse, no load; rxbyte keeps its previous value.
REQ-037 0.5-bit low glitch on rxd -> no load, no frame_err; assert reset mid-TX -> txd=1 in the next cycle, ready=1 after release.
REQ-038 Built with UART_PARITY_EN: 0x07 with parity bit 1 -> load; same byte with parity bit 0 -> frame_err.

Source files
------------

// File: rtl/uart_iobridge_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_iobridge_pkg
//  Description : Shared constants and FSM state encodings for the UART
//                I/O bridge. Parity states exist only when UART_PARITY_EN
//                is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
package uart_iobridge_pkg;

    // Ticks per bit and the tick index at which a bit is sampled
    localparam int OVERSAMPLE = 16;
    localparam int MIDBIT     = 8;

    // Receive FSM encodings
    localparam logic [2:0] R_IDLE  = 3'd0;
    localparam logic [2:0] R_START = 3'd1;
    localparam logic [2:0] R_DATA  = 3'd2;
    localparam logic [2:0] R_STOP  = 3'd3;
`ifdef UART_PARITY_EN
    localparam logic [2:0] R_PAR   = 3'd4;
`endif

    // Transmit FSM encodings
    localparam logic [2:0] T_IDLE  = 3'd0;
    localparam logic [2:0] T_START = 3'd1;
    localparam logic [2:0] T_DATA  = 3'd2;
    localparam logic [2:0] T_STOP  = 3'd3;
    localparam logic [2:0] T_WAIT  = 3'd4;
`ifdef UART_PARITY_EN
    localparam logic [2:0] T_PAR   = 3'd5;

    // Even parity: the bit that makes the total count of ones even
    function automatic logic even_parity(input logic [7:0] d);
        return ^d;
    endfunction
`endif

endpackage
`default_nettype wire

// File: rtl/uart_baudgen.sv
`default_nettype none
// ============================================================================
//  Module      : uart_baudgen
//  Description : Free-running 16x oversample tick generator. Emits a single
//                cycle tick every BAUD_DIV clk cycles, counting from reset
//                release. One instance is shared by RX and TX.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_baudgen #(
    parameter int BAUD_DIV = 54
) (
    input  logic clk,
    input  logic reset,
    output logic o_tick
);

    localparam logic [15:0] c_last = 16'(BAUD_DIV - 1);

    logic [15:0] r_cnt;

    // Divider counter wraps at BAUD_DIV-1
    always_ff @(posedge clk) begin
        if (reset)
            r_cnt <= 16'd0;
        else if (r_cnt == c_last)
            r_cnt <= 16'd0;
        else
            r_cnt <= r_cnt + 16'd1;
    end

    assign o_tick = (r_cnt == c_last);

endmodule
`default_nettype wire

// File: rtl/uart_iobridge.sv
`default_nettype none
// ============================================================================
//  Module      : uart_iobridge
//  Description : UART bridge between a host serial link and an I/O port
//                block. Independent RX and TX FSMs share one baud tick.
//                Default frame is 8N1; defining UART_PARITY_EN adds an
//                even-parity bit on both directions (11-bit frame).
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_iobridge #(
    parameter int BAUD_DIV = 54
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rxd,
    output logic       txd,
    output logic [7:0] rxbyte,
    output logic       load,
    input  logic [7:0] txbyte,
    input  logic       enout,
    output logic       ready,
    output logic       frame_err
);

    import uart_iobridge_pkg::*;

    localparam logic [3:0] c_last_tick = 4'(OVERSAMPLE - 1);
    localparam logic [3:0] c_mid_tick  = 4'(MIDBIT - 1);

    logic w_tick;

    uart_baudgen #(.BAUD_DIV(BAUD_DIV)) u_baudgen (
        .clk    (clk),
        .reset  (reset),
        .o_tick (w_tick)
    );

    // ------------------------------------------------------------------
    // RX path
    // ------------------------------------------------------------------
    logic       r_rxd_meta, r_rxd_sync, r_rxd_prev;
    logic [2:0] r_rx_state, w_rx_state_n;
    logic [3:0] r_rx_tcnt,  w_rx_tcnt_n;
    logic [2:0] r_rx_bcnt,  w_rx_bcnt_n;
    logic [7:0] r_rx_shift, w_rx_shift_n;
    logic [7:0] r_rxbyte,   w_rxbyte_n;
    logic       r_load,     w_load_n;
    logic       r_ferr,     w_ferr_n;
`ifdef UART_PARITY_EN
    logic       r_rx_perr,  w_rx_perr_n;
`endif

    // Two-flop synchronizer plus one history flop for falling-edge detect
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rxd_meta <= 1'b1;
            r_rxd_sync <= 1'b1;
            r_rxd_prev <= 1'b1;
        end else begin
            r_rxd_meta <= rxd;
            r_rxd_sync <= r_rxd_meta;
            r_rxd_prev <= r_rxd_sync;
        end
    end

    // RX next-state, sampling and strobe generation
    always_comb begin
        w_rx_state_n = r_rx_state;
        w_rx_tcnt_n  = r_rx_tcnt;
        w_rx_bcnt_n  = r_rx_bcnt;
        w_rx_shift_n = r_rx_shift;
        w_rxbyte_n   = r_rxbyte;
        w_load_n     = 1'b0;
        w_ferr_n     = 1'b0;
`ifdef UART_PARITY_EN
        w_rx_perr_n  = r_rx_perr;
`endif
        case (r_rx_state)
            R_IDLE: begin
                if (r_rxd_prev && !r_rxd_sync) begin
                    w_rx_state_n = R_START;
                    w_rx_tcnt_n  = 4'd0;
                end
            end
            R_START: begin
                if (w_tick) begin
                    if (r_rx_tcnt == c_mid_tick) begin
                        // High at mid-start means the edge was a glitch
                        if (r_rxd_sync) begin
                            w_rx_state_n = R_IDLE;
                        end else begin
                            w_rx_state_n = R_DATA;
                            w_rx_tcnt_n  = 4'd0;
                            w_rx_bcnt_n  = 3'd0;
                        end
                    end else begin
                        w_rx_tcnt_n = r_rx_tcnt + 4'd1;
                    end
                end
            end
            R_DATA: begin
                if (w_tick) begin
                    if (r_rx_tcnt == c_last_tick) begin
                        w_rx_shift_n = {r_rxd_sync, r_rx_shift[7:1]};
                        w_rx_tcnt_n  = 4'd0;
                        if (r_rx_bcnt == 3'd7) begin
`ifdef UART_PARITY_EN
                            w_rx_state_n = R_PAR;
`else
                            w_rx_state_n = R_STOP;
`endif
                        end else begin
                            w_rx_bcnt_n = r_rx_bcnt + 3'd1;
                        end
                    end else begin
                        w_rx_tcnt_n = r_rx_tcnt + 4'd1;
                    end
                end
            end
`ifdef UART_PARITY_EN
            R_PAR: begin
                if (w_tick) begin
                    if (r_rx_tcnt == c_last_tick) begin
                        w_rx_perr_n  = even_parity(r_rx_shift) ^ r_rxd_sync;
                        w_rx_state_n = R_STOP;
                        w_rx_tcnt_n  = 4'd0;
                    end else begin
                        w_rx_tcnt_n = r_rx_tcnt + 4'd1;
                    end
                end
            end
`endif
            R_STOP: begin
                if (w_tick) begin
                    if (r_rx_tcnt == c_last_tick) begin
                        // Return to idle at mid-stop so a following start bit is seen
                        w_rx_state_n = R_IDLE;
`ifdef UART_PARITY_EN
                        if (r_rxd_sync && !r_rx_perr) begin
`else
                        if (r_rxd_sync) begin
`endif
                            w_load_n   = 1'b1;
                            w_rxbyte_n = r_rx_shift;
                        end else begin
                            w_ferr_n = 1'b1;
                        end
                    end else begin
                        w_rx_tcnt_n = r_rx_tcnt + 4'd1;
                    end
                end
            end
            default: w_rx_state_n = R_IDLE;
        endcase
    end

    // RX state and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rx_state <= R_IDLE;
            r_rx_tcnt  <= 4'd0;
            r_rx_bcnt  <= 3'd0;
            r_rx_shift <= 8'd0;
            r_rxbyte   <= 8'd0;
            r_load     <= 1'b0;
            r_ferr     <= 1'b0;
`ifdef UART_PARITY_EN
            r_rx_perr  <= 1'b0;
`endif
        end else begin
            r_rx_state <= w_rx_state_n;
            r_rx_tcnt  <= w_rx_tcnt_n;
            r_rx_bcnt  <= w_rx_bcnt_n;
            r_rx_shift <= w_rx_shift_n;
            r_rxbyte   <= w_rxbyte_n;
            r_load     <= w_load_n;
            r_ferr     <= w_ferr_n;
`ifdef UART_PARITY_EN
            r_rx_perr  <= w_rx_perr_n;
`endif
        end
    end

    assign rxbyte    = r_rxbyte;
    assign load      = r_load;
    assign frame_err = r_ferr;

    // ------------------------------------------------------------------
    // TX path
    // ------------------------------------------------------------------
    logic [2:0] r_tx_state, w_tx_state_n;
    logic [3:0] r_tx_tcnt,  w_tx_tcnt_n;
    logic [2:0] r_tx_bcnt,  w_tx_bcnt_n;
    logic [7:0] r_tx_data,  w_tx_data_n;
    logic       r_txd,      w_txd_n;
    logic       r_ready,    w_ready_n;

    // TX next-state; txd and ready are derived from the next state so they
    // change in the same cycle as the state register
    always_comb begin
        w_tx_state_n = r_tx_state;
        w_tx_tcnt_n  = r_tx_tcnt;
        w_tx_bcnt_n  = r_tx_bcnt;
        w_tx_data_n  = r_tx_data;
        case (r_tx_state)
            T_IDLE: begin
                if (enout) begin
                    w_tx_data_n  = txbyte;
                    w_tx_state_n = T_START;
                    w_tx_tcnt_n  = 4'd0;
                end
            end
            T_START: begin
                if (w_tick) begin
                    if (r_tx_tcnt == c_last_tick) begin
                        w_tx_state_n = T_DATA;
                        w_tx_tcnt_n  = 4'd0;
                        w_tx_bcnt_n  = 3'd0;
                    end else begin
                        w_tx_tcnt_n = r_tx_tcnt + 4'd1;
                    end
                end
            end
            T_DATA: begin
                if (w_tick) begin
                    if (r_tx_tcnt == c_last_tick) begin
                        w_tx_tcnt_n = 4'd0;
                        if (r_tx_bcnt == 3'd7) begin
`ifdef UART_PARITY_EN
                            w_tx_state_n = T_PAR;
`else
                            w_tx_state_n = T_STOP;
`endif
                        end else begin
                            w_tx_bcnt_n = r_tx_bcnt + 3'd1;
                        end
                    end else begin
                        w_tx_tcnt_n = r_tx_tcnt + 4'd1;
                    end
                end
            end
`ifdef UART_PARITY_EN
            T_PAR: begin
                if (w_tick) begin
                    if (r_tx_tcnt == c_last_tick) begin
                        w_tx_state_n = T_STOP;
                        w_tx_tcnt_n  = 4'd0;
                    end else begin
                        w_tx_tcnt_n = r_tx_tcnt + 4'd1;
                    end
                end
            end
`endif
            T_STOP: begin
                if (w_tick) begin
                    if (r_tx_tcnt == c_last_tick) begin
                        w_tx_state_n = T_WAIT;
                        w_tx_tcnt_n  = 4'd0;
                    end else begin
                        w_tx_tcnt_n = r_tx_tcnt + 4'd1;
                    end
                end
            end
            T_WAIT: begin
                // Hold off until the port block drops enout so one byte is sent once
                if (!enout)
                    w_tx_state_n = T_IDLE;
            end
            default: w_tx_state_n = T_IDLE;
        endcase

        case (w_tx_state_n)
            T_START: w_txd_n = 1'b0;
            T_DATA:  w_txd_n = w_tx_data_n[w_tx_bcnt_n];
`ifdef UART_PARITY_EN
            T_PAR:   w_txd_n = even_parity(w_tx_data_n);
`endif
            default: w_txd_n = 1'b1;
        endcase
        w_ready_n = (w_tx_state_n == T_IDLE);
    end

    // TX state and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            r_tx_state <= T_IDLE;
            r_tx_tcnt  <= 4'd0;
            r_tx_bcnt  <= 3'd0;
            r_tx_data  <= 8'd0;
            r_txd      <= 1'b1;
            r_ready    <= 1'b0;
        end else begin
            r_tx_state <= w_tx_state_n;
            r_tx_tcnt  <= w_tx_tcnt_n;
            r_tx_bcnt  <= w_tx_bcnt_n;
            r_tx_data  <= w_tx_data_n;
            r_txd      <= w_txd_n;
            r_ready    <= w_ready_n;
        end
    end

    assign txd   = r_txd;
    assign ready = r_ready;

endmodule
`default_nettype wire
